// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// Module      : seq_divider
// Description : Sequential signed radix-2 restoring divider, one quotient bit
//               per clock, start/ready handshake shared with the multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_divider #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic                  busy,
    output logic                  ready,
    output logic [DATA_WIDTH-1:0] quotient,
    output logic [DATA_WIDTH-1:0] remainder,
    output logic                  div_zero,
    output logic                  overflow
);

    localparam int c_CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(DATA_WIDTH - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_LOAD = 2'd1;
    localparam logic [1:0] c_CALC = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    logic [1:0]            r_state;
    logic [1:0]            w_next_state;

    logic [DATA_WIDTH-1:0] r_op_a;
    logic [DATA_WIDTH-1:0] r_op_b;
    logic [DATA_WIDTH:0]   r_rem;
    logic [DATA_WIDTH-1:0] r_quo;
    logic [DATA_WIDTH:0]   r_dmag;
    logic                  r_sign_q;
    logic                  r_sign_r;
    logic [c_CW-1:0]       r_cnt;

    logic [DATA_WIDTH-1:0] r_quotient;
    logic [DATA_WIDTH-1:0] r_remainder;
    logic                  r_div_zero;
    logic                  r_overflow;

    logic [DATA_WIDTH-1:0] w_a_mag;
    logic [DATA_WIDTH-1:0] w_b_mag;
    logic [DATA_WIDTH:0]   w_shift;
    logic [DATA_WIDTH:0]   w_trial;
    logic                  w_trial_ok;
    logic [DATA_WIDTH:0]   w_rem_next;
    logic [DATA_WIDTH-1:0] w_quo_next;
    logic [DATA_WIDTH-1:0] w_q_signed;
    logic [DATA_WIDTH-1:0] w_r_signed;
    logic                  w_ovf;
    logic                  w_last;
    logic                  w_b_zero;

    // Magnitudes as unsigned DATA_WIDTH values: the most-negative input maps exactly.
    assign w_a_mag    = r_op_a[DATA_WIDTH-1] ? (~r_op_a + 1'b1) : r_op_a;
    assign w_b_mag    = r_op_b[DATA_WIDTH-1] ? (~r_op_b + 1'b1) : r_op_b;
    assign w_b_zero   = (r_op_b == '0);

    assign w_shift    = {r_rem[DATA_WIDTH-1:0], r_quo[DATA_WIDTH-1]};
    assign w_trial    = w_shift - r_dmag;
    assign w_trial_ok = ~w_trial[DATA_WIDTH];
    assign w_rem_next = w_trial_ok ? w_trial : w_shift;
    assign w_quo_next = {r_quo[DATA_WIDTH-2:0], w_trial_ok};
    assign w_last     = (r_cnt == c_LAST);

    assign w_q_signed = r_sign_q ? (~w_quo_next + 1'b1) : w_quo_next;
    assign w_r_signed = r_sign_r ? (~w_rem_next[DATA_WIDTH-1:0] + 1'b1)
                                 : w_rem_next[DATA_WIDTH-1:0];
    // A positive quotient with its MSB set can only be most-negative / -1.
    assign w_ovf      = ~r_sign_q & w_quo_next[DATA_WIDTH-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: if (start) w_next_state = c_LOAD;
            c_LOAD: w_next_state = w_b_zero ? c_DONE : c_CALC;
            c_CALC: if (w_last) w_next_state = c_DONE;
            c_DONE: w_next_state = c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_dmag      <= '0;
            r_sign_q    <= 1'b0;
            r_sign_r    <= 1'b0;
            r_cnt       <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_div_zero  <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_op_a <= dividend;
                        r_op_b <= divisor;
                    end
                end
                c_LOAD: begin
                    r_rem    <= '0;
                    r_quo    <= w_a_mag;
                    r_dmag   <= {1'b0, w_b_mag};
                    r_sign_q <= r_op_a[DATA_WIDTH-1] ^ r_op_b[DATA_WIDTH-1];
                    r_sign_r <= r_op_a[DATA_WIDTH-1];
                    r_cnt    <= '0;
                    if (w_b_zero) begin
                        r_quotient  <= '1;
                        r_remainder <= r_op_a;
                        r_div_zero  <= 1'b1;
                        r_overflow  <= 1'b0;
                    end
                end
                c_CALC: begin
                    r_rem <= w_rem_next;
                    r_quo <= w_quo_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_quotient  <= w_q_signed;
                        r_remainder <= w_r_signed;
                        r_div_zero  <= 1'b0;
                        r_overflow  <= w_ovf;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy      = (r_state != c_IDLE);
    assign ready     = (r_state == c_DONE);
    assign quotient  = r_quotient;
    assign remainder = r_remainder;
    assign div_zero  = r_div_zero;
    assign overflow  = r_overflow;

endmodule
`default_nettype wire
